// File: rtl/posit_mul_arbiter_if.sv
// Bundle of requester, response and posit_mul core signals shared by the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface posit_mul_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_data;
    logic                  rsp_err;
    logic [2:0]            grant_id;
    logic                  busy;
    logic                  mul_start;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic [31:0]           mul_result;
    logic                  mul_done;
    logic                  mul_rst_n;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, grant_id, busy,
               mul_start, mul_a, mul_b, mul_rst_n
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, grant_id, busy,
               mul_start, mul_a, mul_b, mul_rst_n
    );
endinterface

// File: rtl/posit_mul_arbiter.sv
// Round-robin scheduler sharing one posit_mul core among NUM_REQ requesters,
// with zero/NaR short-circuit and timeout recovery of a hung core.
module posit_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int LAT_W   = 8
) (
    input logic               clk,
    input logic               rst,
    posit_mul_arbiter_if.slave bus
);
    localparam logic [31:0] NAR = 32'h8000_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FLUSH, RESP} state_t;

    state_t             state, state_d;
    logic [LAT_W-1:0]   cnt;
    logic               flush_cnt;
    logic [2:0]         last_grant;
    logic [2:0]         grant_id_r;
    logic [31:0]        mul_a_r, mul_b_r;
    logic [31:0]        rsp_data_r;
    logic               rsp_err_r;

    logic [NUM_REQ-1:0] rot;
    logic [3:0]         sum;
    logic [2:0]         gnt;
    logic               gnt_found;
    logic [31:0]        sel_a, sel_b;
    logic               fast_hit;
    logic [31:0]        fast_val;
    logic [NUM_REQ-1:0] rsp_vec;
    logic               rsp_hit;

    // Rotate so bit 0 is the requester right after last_grant; the first set
    // bit of the rotated vector is the round-robin winner.
    always_comb begin
        rot       = NUM_REQ'({bus.req_valid, bus.req_valid} >> (last_grant + 3'd1));
        sum       = '0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && rot[i]) begin
                gnt_found = 1'b1;
                sum       = {1'b0, last_grant} + 4'd1 + 4'(i);
                if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
                gnt       = sum[2:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt == 3'(j)) begin
                sel_a = bus.req_a[j*32 +: 32];
                sel_b = bus.req_b[j*32 +: 32];
            end
        end
        fast_hit = (sel_a == NAR) || (sel_b == NAR) || (sel_a == '0) || (sel_b == '0);
        fast_val = ((sel_a == NAR) || (sel_b == NAR)) ? NAR : 32'h0;
    end

    assign rsp_vec = (state == RESP) ? (NUM_REQ'(1) << grant_id_r) : '0;
    assign rsp_hit = |(bus.rsp_ready & rsp_vec);

    always_comb begin
        state_d       = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (gnt_found && !rst) begin
                    bus.req_ready = NUM_REQ'(1) << gnt;
                    state_d       = fast_hit ? RESP : ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.mul_done)                  state_d = RESP;
                else if (cnt == LAT_W'(TIMEOUT))   state_d = FLUSH;
            end
            FLUSH: if (flush_cnt) state_d = RESP;
            RESP:  if (rsp_hit)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_cnt  <= 1'b0;
            last_grant <= 3'(NUM_REQ - 1);
            grant_id_r <= '0;
            mul_a_r    <= '0;
            mul_b_r    <= '0;
            rsp_data_r <= '0;
            rsp_err_r  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        grant_id_r <= gnt;
                        mul_a_r    <= sel_a;
                        mul_b_r    <= sel_b;
                        if (fast_hit) begin
                            rsp_data_r <= fast_val;
                            rsp_err_r  <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    cnt       <= '0;
                    flush_cnt <= 1'b0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // done beats a coincident timeout
                    if (bus.mul_done) begin
                        rsp_data_r <= bus.mul_result;
                        rsp_err_r  <= 1'b0;
                    end else if (cnt == LAT_W'(TIMEOUT)) begin
                        rsp_data_r <= NAR;
                        rsp_err_r  <= 1'b1;
                    end
                end
                FLUSH: flush_cnt <= 1'b1;
                RESP:  if (rsp_hit) last_grant <= grant_id_r;
                default: ;
            endcase
        end
    end

    assign bus.mul_start = (state == ISSUE);
    assign bus.busy      = (state != IDLE);
    assign bus.mul_rst_n = !rst && (state != FLUSH);
    assign bus.rsp_valid = rsp_vec;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.grant_id  = grant_id_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Bench for posit_mul_arbiter: latency-programmable core stub, directed scenarios
// and randomized transactions checked against a behavioural reference model.
module tb_posit_mul_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 255;
    localparam logic [31:0] NAR = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    posit_mul_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    posit_mul_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT), .LAT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          model_last = NUM_REQ - 1;

    // core stub
    int          stub_lat = 10;
    bit          stub_hang = 1'b0;
    logic [31:0] stub_result = '0;
    bit          stray_done = 1'b0;
    logic        core_done = 1'b0;
    int          rem = 0;

    assign bus.mul_done   = core_done | stray_done;
    assign bus.mul_result = stub_result;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (!bus.mul_rst_n) begin
            rem <= 0; core_done <= 1'b0;
        end else if (bus.mul_start && !stub_hang) begin
            rem <= stub_lat - 1; core_done <= (stub_lat == 1);
        end else if (rem != 0) begin
            rem <= rem - 1; core_done <= (rem == 1);
        end else begin
            core_done <= 1'b0;
        end
    end

    int n_start = 0;
    int n_low = 0;
    int low_start = 0;
    bit prev_rstn = 1'b0;
    always @(negedge clk) begin
        if (bus.mul_start) n_start <= n_start + 1;
        if (!bus.mul_rst_n) begin
            n_low <= n_low + 1;
            if (prev_rstn) low_start <= cyc;
        end
        prev_rstn <= bus.mul_rst_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: posit products involving NaR are NaR, involving zero are zero.
    function automatic logic [32:0] ref_fast(input logic [31:0] a, input logic [31:0] b);
        if (a == NAR || b == NAR) return {1'b1, NAR};
        if (a == 32'h0 || b == 32'h0) return {1'b1, 32'h0};
        return {1'b0, 32'h0};
    endfunction

    function automatic int next_grant(input logic [NUM_REQ-1:0] v, input int last);
        for (int off = 1; off <= NUM_REQ; off++) begin
            int i;
            i = (last + off) % NUM_REQ;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return NAR;
            1: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_accept(input string tag, input logic [NUM_REQ-1:0] exp_vec, output int t);
        bit got = 1'b0;
        t = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin got = 1'b1; t = cyc; break; end
        end
        check({tag, "_accepted"}, 32'(got), 32'd1);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(exp_vec));
    endtask

    task automatic wait_rsp(input string tag, output int t);
        bit got = 1'b0;
        t = 0;
        for (int k = 0; k < 400; k++) begin
            if (bus.rsp_valid != '0) begin got = 1'b1; t = cyc; break; end
            @(negedge clk);
        end
        check({tag, "_rsp_seen"}, 32'(got), 32'd1);
    endtask

    task automatic handshake(input string tag, input int r);
        @(posedge clk); #1 bus.rsp_ready[r] = 1'b1;
        @(posedge clk); #1 bus.rsp_ready[r] = 1'b0;
        model_last = r;
        @(negedge clk);
        check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_idle"}, 32'(bus.busy), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({tag, "_rsp_data"},  bus.rsp_data, 32'h0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'h0);
        check({tag, "_mul_start"}, 32'(bus.mul_start), 32'h0);
        check({tag, "_mul_a"},     bus.mul_a, 32'h0);
        check({tag, "_mul_b"},     bus.mul_b, 32'h0);
        check({tag, "_busy"},      32'(bus.busy), 32'h0);
        check({tag, "_grant_id"},  32'(bus.grant_id), 32'h0);
    endtask

    task automatic txn(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input bit hang, input logic [31:0] res, input int bp);
        logic [32:0] fr;
        logic [31:0] exp_data;
        bit          fast, exp_err;
        int          exp_lat, t0, t1, s0, l0, g;
        fr       = ref_fast(a, b);
        fast     = fr[32];
        exp_data = fast ? fr[31:0] : (hang ? NAR : res);
        exp_err  = !fast && hang;
        exp_lat  = fast ? 1 : (hang ? TIMEOUT + 5 : lat + 2);
        g        = next_grant(NUM_REQ'(1) << r, model_last);
        @(posedge clk); #1;
        stub_lat = lat; stub_hang = hang; stub_result = res;
        bus.req_a[r*32 +: 32] = a;
        bus.req_b[r*32 +: 32] = b;
        bus.req_valid[r] = 1'b1;
        s0 = n_start; l0 = n_low;
        wait_accept(tag, NUM_REQ'(1) << g, t0);
        @(posedge clk); #1 bus.req_valid[r] = 1'b0;
        @(negedge clk);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 32'(g));
        check({tag, "_mul_a"}, bus.mul_a, a);
        check({tag, "_mul_b"}, bus.mul_b, b);
        wait_rsp(tag, t1);
        check({tag, "_latency"}, 32'(t1 - t0), 32'(exp_lat));
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(NUM_REQ'(1) << r));
        check({tag, "_rsp_data"}, bus.rsp_data, exp_data);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, "_starts"}, 32'(n_start - s0), fast ? 32'd0 : 32'd1);
        check({tag, "_core_rst_cycles"}, 32'(n_low - l0), exp_err ? 32'd2 : 32'd0);
        if (exp_err) check({tag, "_flush_start"}, 32'(low_start - t0), 32'(TIMEOUT + 3));
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check({tag, "_hold_data"}, bus.rsp_data, exp_data);
        end
        handshake(tag, r);
    endtask

    int t0, t1;
    bit got;

    initial begin
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_core_rst_n", 32'(bus.mul_rst_n), 32'h0);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("run_core_rst_n", 32'(bus.mul_rst_n), 32'h1);
        model_last = NUM_REQ - 1;

        // Basic core path, then both short-circuit kinds
        txn("basic", 0, 32'h4000_0000, 32'h4400_0000, 10, 1'b0, 32'h4400_0000, 0);
        txn("fast_nar", 2, NAR, 32'h4000_0000, 10, 1'b0, 32'h1111_1111, 2);
        txn("fast_zero", 2, 32'h0, 32'h4000_0000, 10, 1'b0, 32'h2222_2222, 0);

        // All requesters continuously valid
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_a[i*32 +: 32] = 32'h4000_0000;
            bus.req_b[i*32 +: 32] = 32'h4400_0000;
        end
        stub_lat = 3; stub_hang = 1'b0; stub_result = 32'h3000_0000;
        bus.req_valid = '1; bus.rsp_ready = '1;
        for (int g = 0; g < 5; g++) begin
            int e;
            e = next_grant('1, model_last);
            wait_accept("fair", NUM_REQ'(1) << e, t0);
            model_last = e;
        end
        @(posedge clk); #1 bus.req_valid = '0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.busy) begin got = 1'b1; break; end
        end
        check("fair_drain", 32'(got), 32'd1);
        @(posedge clk); #1 bus.rsp_ready = '0;

        // Hung core, then a normal request afterwards
        txn("timeout", 1, 32'h4000_0000, 32'h4800_0000, 5, 1'b1, 32'h5555_5555, 0);
        txn("after_tmo", 1, 32'h4000_0000, 32'h4800_0000, 4, 1'b0, 32'h4C00_0000, 0);

        // Response backpressure with another requester waiting
        @(posedge clk); #1;
        bus.req_a[32 +: 32] = 32'h0; bus.req_b[32 +: 32] = 32'h1234_5678;
        bus.req_valid = 4'b0010;
        wait_accept("bp", NUM_REQ'(1) << next_grant(4'b0010, model_last), t0);
        @(posedge clk); #1;
        stub_lat = 5; stub_hang = 1'b0; stub_result = 32'h4A00_0000;
        bus.req_a[96 +: 32] = 32'h4000_0000; bus.req_b[96 +: 32] = 32'h4400_0000;
        bus.req_valid = 4'b1000;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h2);
            check("bp_rsp_data", bus.rsp_data, 32'h0);
            check("bp_req_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk); #1 bus.rsp_ready = 4'b0010;
        @(negedge clk);
        check("bp_hs_req_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1 bus.rsp_ready = '0;
        model_last = 1;
        @(negedge clk);
        check("bp_next_grant", 32'(bus.req_ready), 32'(NUM_REQ'(1) << next_grant(4'b1000, model_last)));
        t0 = cyc;
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        wait_rsp("bp_req3", t1);
        check("bp_req3_latency", 32'(t1 - t0), 32'd7);
        check("bp_req3_data", bus.rsp_data, 32'h4A00_0000);
        handshake("bp_req3", 3);

        // Reset in the middle of WAIT
        @(posedge clk); #1;
        stub_lat = 30; stub_result = 32'h7777_7777;
        bus.req_a[64 +: 32] = 32'h4000_0000; bus.req_b[64 +: 32] = 32'h4800_0000;
        bus.req_valid = 4'b0100;
        wait_accept("midrst", NUM_REQ'(1) << next_grant(4'b0100, model_last), t0);
        @(posedge clk); #1 bus.req_valid = '0;
        repeat (5) @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_core_rst_n", 32'(bus.mul_rst_n), 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        check("midrst_core_rst_rel", 32'(bus.mul_rst_n), 32'h1);
        model_last = NUM_REQ - 1;
        @(posedge clk); #1 stray_done = 1'b1;
        @(posedge clk); #1 stray_done = 1'b0;
        @(negedge clk);
        check("stray_busy", 32'(bus.busy), 32'h0);
        check("stray_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk); #1;
        stub_lat = 4; stub_result = 32'h4100_0000;
        bus.req_a[0 +: 32] = 32'h4000_0000; bus.req_b[0 +: 32] = 32'h4100_0000;
        bus.req_valid = 4'b0101;
        wait_accept("post_rst", NUM_REQ'(1) << next_grant(4'b0101, model_last), t0);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk);
        wait_rsp("post_rst", t1);
        check("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("post_rst_data", bus.rsp_data, 32'h4100_0000);
        handshake("post_rst", 0);

        // Randomized transactions
        for (int n = 0; n < 25; n++) begin
            txn("rand", int'($urandom_range(0, NUM_REQ - 1)), pick_op(), pick_op(),
                int'($urandom_range(1, 15)), 1'b0, $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/posit_mul_arbiter.md
Name: posit_mul_arbiter

Overview:
Round-robin scheduler that shares one posit_mul core (32-bit posit, ES=3) among NUM_REQ requesters.
- Accepts one operand pair at a time, issues a single-cycle start to the core and waits for its done.
- Returns the result to the granted requester over a valid/ready response channel.
- Short-circuits zero/NaR operands without using the core.
- Recovers from a hung core by timeout and core reset.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles in WAIT before abort (counter width 8)
LAT_W, 8, width of the timeout counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  one-hot pulse: operands of that requester accepted this cycle
req_a  in  32*NUM_REQ  operand A, slice i = bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand B, same slicing
rsp_valid  out  NUM_REQ  one-hot: result for requester i valid
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_data  out  32  result posit (shared bus)
rsp_err  out  1  qualifies rsp_data: 1 = timeout abort
grant_id  out  3  index of current/last granted requester
busy  out  1  high in any state other than IDLE
mul_start  out  1  to core start, single-cycle pulse
mul_a  out  32  to core posit_a
mul_b  out  32  to core posit_b
mul_result  in  32  from core posit_result
mul_done  in  1  from core done
mul_rst_n  out  1  active-low reset to core

Behaviour:
Reset values:
- req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0, busy=0, grant_id=0.
- mul_rst_n=0 while rst=1.
- last_grant=NUM_REQ-1, so requester 0 has first priority. State=IDLE.
- rst at any point aborts the operation in flight: no response is produced, and requesters must re-present their requests.

FSM states: IDLE, ISSUE, WAIT, FLUSH, RESP.

IDLE:
- If any req_valid, grant the first set bit searching from last_grant+1 with wrap-around.
- In the same cycle: pulse req_ready[g]=1, latch req_a/req_b slice g into mul_a/mul_b, set grant_id=g.
- Fast path, evaluated on the latched operands:
  - If either operand is 0x8000_0000, the result is NaR 0x8000_0000.
  - Otherwise, if either operand is 0x0000_0000, the result is 0x0000_0000.
  - A fast-path request goes to RESP with rsp_err=0 and no mul_start.
- Any other request goes to ISSUE.

ISSUE:
- mul_start=1 for exactly one cycle; clear the counter; go to WAIT.
- mul_a/mul_b stay stable from the latch until the next grant.

WAIT:
- The counter increments every cycle.
- mul_done=1: capture mul_result into rsp_data, set rsp_err=0, go to RESP.
- Otherwise, counter==TIMEOUT: set rsp_data=0x8000_0000, rsp_err=1, go to FLUSH.
- mul_done and timeout in the same cycle: done wins.

FLUSH:
- Drive mul_rst_n=0 for exactly 2 cycles, then go to RESP.
- mul_rst_n=1 in all other states.

RESP:
- rsp_valid[grant_id]=1; rsp_data and rsp_err held stable.
- When rsp_ready[grant_id]=1: drop rsp_valid next cycle, set last_grant=grant_id, go to IDLE.
- rsp_ready of non-granted requesters is ignored.

Stray mul_done outside WAIT is ignored. No new grant is issued until the response handshake completes, so at most one operation is outstanding.

Latency:
- Accept at cycle T, mul_start at T+1.
- If the core asserts done at T+1+L, rsp_valid rises at T+2+L.
- Fast path: rsp_valid at T+1.
- Timeout: rsp_valid at T+TIMEOUT+5.

Fairness: a requester holding req_valid continuously is granted within NUM_REQ grants.

Test Plan:
- Bench core stub: fixed latency 10, returns 0x4400_0000. Req0 presents a=0x4000_0000, b=0x4400_0000 → req_ready[0] pulse at T, mul_start at T+1, rsp_valid[0] at T+12 with rsp_data=0x4400_0000, rsp_err=0.
- All four req_valid held high, rsp_ready tied 1 → grant order 0,1,2,3,0; req_ready pulses one-hot; no requester is skipped.
- Fast path:
  - Req2 with a=0x8000_0000, b=0x4000_0000 → no mul_start; rsp_valid[2] at T+1 with rsp_data=0x8000_0000.
  - a=0, b=0x4000_0000 → rsp_data=0x0000_0000.
- Stub never asserts done → mul_rst_n low for 2 cycles starting T+TIMEOUT+3; rsp_data=0x8000_0000, rsp_err=1. The next request then completes normally.
- Backpressure: rsp_ready[1]=0 for 20 cycles while req3 is valid → rsp_valid[1] and rsp_data stay stable, req_ready[3] stays 0. Release → req3 is granted the cycle after the handshake.
- Assert rst for 1 cycle mid-WAIT → all outputs return to reset values, mul_rst_n=0 during rst, FSM in IDLE. A late mul_done is ignored, and the next grant goes to req0.
